// File: rtl/keypad_scanner.sv
// Row-strobed matrix keypad scanner. Each row is driven for SCAN_DIV clocks and its columns are
// snapshotted. A full frame is accepted once it has repeated for DEBOUNCE frames.
module keypad_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 3,
    parameter int KEY_W    = $clog2(ROWS*COLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [COLS-1:0]  col_sense,
    output logic [ROWS-1:0]  row_drive,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             multi,
    output logic             press,
    output logic             key_release
);
    localparam int N  = ROWS*COLS;
    localparam int DW = $clog2(SCAN_DIV);
    localparam int RW = $clog2(ROWS);
    localparam int SW = $clog2(DEBOUNCE+1);
    localparam int CW = $clog2(N+1);

    logic [COLS-1:0]  col_s1_q, col_s2_q;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [RW-1:0]    row_q, row_d;
    logic [N-1:0]     snap_q, snap_d;
    logic [N-1:0]     last_q, last_d;
    logic [N-1:0]     acc_q, acc_d;
    logic [SW-1:0]    stable_q, stable_d;
    logic [KEY_W-1:0] key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             multi_q, multi_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic [N-1:0]     full;
    logic [CW-1:0]    ones;
    logic [KEY_W-1:0] idx;

    always_comb begin
        dwell_d     = dwell_q;
        row_d       = row_q;
        snap_d      = snap_q;
        last_d      = last_q;
        acc_d       = acc_q;
        stable_d    = stable_q;
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        multi_d     = multi_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        full        = snap_q;
        ones        = '0;
        idx         = key_code_q;
        if (en) begin
            if (dwell_q == DW'(SCAN_DIV-1)) begin
                dwell_d = '0;
                snap_d[row_q*COLS +: COLS] = col_s2_q;
                if (row_q == RW'(ROWS-1)) begin
                    row_d  = '0;
                    full   = snap_d;
                    last_d = full;
                    if (full != last_q)
                        stable_d = SW'(1);
                    else if (stable_q != SW'(DEBOUNCE))
                        stable_d = stable_q + 1'b1;
                    if (stable_d == SW'(DEBOUNCE) && full != acc_q) begin
                        acc_d = full;
                        for (int i = 0; i < N; i++) begin
                            ones = ones + CW'(full[i]);
                            if (full[i]) idx = i[KEY_W-1:0];
                        end
                        key_valid_d = (ones == CW'(1));
                        multi_d     = (ones >= CW'(2));
                        if (key_valid_d) key_code_d = idx;
                        // a change between two single keys is a press without a release
                        press_d   = key_valid_d && (!key_valid_q || idx != key_code_q);
                        release_d = key_valid_q && !key_valid_d;
                    end
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_s1_q    <= '0;
            col_s2_q    <= '0;
            dwell_q     <= '0;
            row_q       <= '0;
            snap_q      <= '0;
            last_q      <= '0;
            acc_q       <= '0;
            stable_q    <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            multi_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            col_s1_q    <= col_sense;
            col_s2_q    <= col_s1_q;
            dwell_q     <= dwell_d;
            row_q       <= row_d;
            snap_q      <= snap_d;
            last_q      <= last_d;
            acc_q       <= acc_d;
            stable_q    <= stable_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            multi_q     <= multi_d;
            press_q     <= press_d;
            release_q   <= release_d;
        end
    end

    assign row_drive   = ROWS'(1) << row_q;
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign multi       = multi_q;
    assign press       = press_q;
    assign key_release = release_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a 4x4 key-matrix model.
// Timing uses SCAN_DIV=4 and DEBOUNCE=3, so one frame is 16 clocks.
module tb_keypad_scanner;
    logic        clk, rst, en;
    logic [3:0]  col_sense;
    logic [3:0]  row_drive;
    logic [3:0]  key_code;
    logic        key_valid, multi, press, key_release;
    logic [15:0] keys;
    int          n_checks, n_pass;
    int          press_cnt, rel_cnt;

    keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clk(clk), .rst(rst), .en(en), .col_sense(col_sense), .row_drive(row_drive),
        .key_code(key_code), .key_valid(key_valid), .multi(multi), .press(press),
        .key_release(key_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        col_sense = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (row_drive[r] && keys[r*4+c]) col_sense[c] = 1'b1;
    end

    initial begin
        press_cnt = 0;
        rel_cnt   = 0;
    end
    always @(negedge clk) begin
        if (press)       press_cnt <= press_cnt + 1;
        if (key_release) rel_cnt   <= rel_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Leaves the bench on the negedge where rst drops; that is cycle 0 of frame 1.
    task automatic reset_dut;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_press(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (press) begin n = i; break; end
        end
    endtask

    task automatic wait_release(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (key_release) begin n = i; break; end
        end
    endtask

    task automatic test_reset;
        logic [3:0] exp_row;
        keys = '0;
        en   = 1'b1;
        reset_dut();
        n_checks++;
        if ({row_drive, key_code, key_valid, multi, press, key_release} !== {4'b0001, 4'd0, 4'b0000})
            $display("FAIL reset_state: got %b want %b",
                     {row_drive, key_code, key_valid, multi, press, key_release}, {4'b0001, 4'd0, 4'b0000});
        else n_pass++;
        for (int k = 0; k < 100; k++) begin
            exp_row = 4'b0001 << ((k / 4) % 4);
            n_checks++;
            if ({row_drive, key_code, key_valid, multi, press, key_release} !== {exp_row, 4'd0, 4'b0000})
                $display("FAIL idle_scan cycle %0d: got %b want %b", k,
                         {row_drive, key_code, key_valid, multi, press, key_release}, {exp_row, 4'd0, 4'b0000});
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_single;
        int n, p0, r0;
        keys = '0;
        reset_dut();
        keys[6] = 1'b1;
        p0 = press_cnt;
        r0 = rel_cnt;
        wait_press(80, n);
        n_checks++;
        if (n !== 48) $display("FAIL single_press_latency: got %0d want 48", n); else n_pass++;
        n_checks++;
        if ({key_code, key_valid, multi, key_release} !== {4'd6, 3'b100})
            $display("FAIL single_press_outputs: got %b want %b", {key_code, key_valid, multi, key_release}, {4'd6, 3'b100});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (press !== 1'b0) $display("FAIL single_press_width: got %b want 0", press); else n_pass++;
        keys[6] = 1'b0;
        wait_release(80, n);
        n_checks++;
        if (n !== 47) $display("FAIL single_release_latency: got %0d want 47", n); else n_pass++;
        n_checks++;
        if ({key_code, key_valid, multi} !== {4'd6, 2'b00})
            $display("FAIL single_release_outputs: got %b want %b", {key_code, key_valid, multi}, {4'd6, 2'b00});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (key_release !== 1'b0) $display("FAIL single_release_width: got %b want 0", key_release); else n_pass++;
        n_checks++;
        if (press_cnt !== p0 + 1 || rel_cnt !== r0 + 1)
            $display("FAIL single_pulse_counts: got press %0d release %0d want %0d %0d",
                     press_cnt - p0, rel_cnt - r0, 1, 1);
        else n_pass++;
    endtask

    task automatic test_glitch;
        int p0;
        bit saw_valid;
        keys = '0;
        reset_dut();
        keys[6]   = 1'b1;
        p0        = press_cnt;
        saw_valid = 1'b0;
        repeat (32) begin
            @(negedge clk);
            if (key_valid) saw_valid = 1'b1;
        end
        keys[6] = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (key_valid) saw_valid = 1'b1;
        end
        n_checks++;
        if (saw_valid !== 1'b0) $display("FAIL glitch_valid: got %b want 0", saw_valid); else n_pass++;
        n_checks++;
        if (press_cnt !== p0) $display("FAIL glitch_press: got %0d presses want 0", press_cnt - p0); else n_pass++;
    endtask

    task automatic test_multi;
        int n, r0;
        keys = '0;
        reset_dut();
        keys[0] = 1'b1;
        wait_press(80, n);
        n_checks++;
        if (n !== 48 || key_valid !== 1'b1) $display("FAIL multi_first_press: got %0d/%b want 48/1", n, key_valid); else n_pass++;
        keys[15] = 1'b1;
        r0 = rel_cnt;
        wait_release(80, n);
        n_checks++;
        if (n !== 48) $display("FAIL multi_release_latency: got %0d want 48", n); else n_pass++;
        n_checks++;
        if ({key_code, key_valid, multi} !== {4'd0, 2'b01})
            $display("FAIL multi_outputs: got %b want %b", {key_code, key_valid, multi}, {4'd0, 2'b01});
        else n_pass++;
        keys[0] = 1'b0;
        wait_press(80, n);
        n_checks++;
        if (n !== 48) $display("FAIL multi_to_single_latency: got %0d want 48", n); else n_pass++;
        n_checks++;
        if ({key_code, key_valid, multi, key_release} !== {4'd15, 3'b100})
            $display("FAIL multi_to_single_outputs: got %b want %b", {key_code, key_valid, multi, key_release}, {4'd15, 3'b100});
        else n_pass++;
        n_checks++;
        if (rel_cnt !== r0 + 1) $display("FAIL multi_release_count: got %0d want 1", rel_cnt - r0); else n_pass++;
    endtask

    // Continues from key 15 accepted: switch straight to key 10.
    task automatic test_back_to_back;
        int n, r0;
        keys = '0;
        keys[10] = 1'b1;
        r0 = rel_cnt;
        wait_press(80, n);
        n_checks++;
        if (n !== 48) $display("FAIL b2b_latency: got %0d want 48", n); else n_pass++;
        n_checks++;
        if ({key_code, key_valid, multi} !== {4'd10, 2'b10})
            $display("FAIL b2b_outputs: got %b want %b", {key_code, key_valid, multi}, {4'd10, 2'b10});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (rel_cnt !== r0) $display("FAIL b2b_no_release: got %0d releases want 0", rel_cnt - r0); else n_pass++;
    endtask

    task automatic test_enable;
        int n;
        keys = '0;
        reset_dut();
        repeat (6) @(negedge clk);
        keys[5] = 1'b1;
        en      = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            n_checks++;
            if ({row_drive, key_code, key_valid, multi, press, key_release} !== {4'b0010, 4'd0, 4'b0000})
                $display("FAIL en_freeze cycle %0d: got %b want %b", k,
                         {row_drive, key_code, key_valid, multi, press, key_release}, {4'b0010, 4'd0, 4'b0000});
            else n_pass++;
        end
        en = 1'b1;
        wait_press(80, n);
        n_checks++;
        if (n !== 42) $display("FAIL en_resume_latency: got %0d want 42", n); else n_pass++;
        n_checks++;
        if ({key_code, key_valid} !== {4'd5, 1'b1})
            $display("FAIL en_resume_outputs: got %b want %b", {key_code, key_valid}, {4'd5, 1'b1});
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int n;
        keys = '0;
        reset_dut();
        keys[9] = 1'b1;
        wait_press(80, n);
        n_checks++;
        if (n !== 48 || key_code !== 4'd9) $display("FAIL rstmid_first: got %0d/%0d want 48/9", n, key_code); else n_pass++;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({row_drive, key_code, key_valid, multi, press, key_release} !== {4'b0001, 4'd0, 4'b0000})
            $display("FAIL rstmid_state: got %b want %b",
                     {row_drive, key_code, key_valid, multi, press, key_release}, {4'b0001, 4'd0, 4'b0000});
        else n_pass++;
        rst = 1'b0;
        wait_press(80, n);
        n_checks++;
        if (n !== 48) $display("FAIL rstmid_relatch_latency: got %0d want 48", n); else n_pass++;
        n_checks++;
        if ({key_code, key_valid} !== {4'd9, 1'b1})
            $display("FAIL rstmid_relatch_outputs: got %b want %b", {key_code, key_valid}, {4'd9, 1'b1});
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        keys     = '0;
        en       = 1'b1;
        rst      = 1'b1;
        test_reset();
        test_single();
        test_glitch();
        test_multi();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
